// File: rtl/bcd_down_counter60_if.sv
// Control and digit bus for the two-digit BCD down-counter.
// master drives load/run/tick and reads digits; slave is the counter itself.
interface bcd_down_counter60_if;
    logic       run;
    logic       tick;
    logic       load;
    logic [3:0] load_low;
    logic [3:0] load_high;
    logic [3:0] low;
    logic [3:0] high;
    logic       bo;
    logic       zero;
    logic       done;
    logic       load_err;

    modport master (
        output run, tick, load, load_low, load_high,
        input  low, high, bo, zero, done, load_err
    );

    modport slave (
        input  run, tick, load, load_low, load_high,
        output low, high, bo, zero, done, load_err
    );
endinterface

// File: rtl/bcd_down_counter60.sv
// Two-digit BCD down-counter with preset load and borrow output for chaining.
// Optional macro TICK_DIV_EN: replaces the tick port with an internal
// prescaler that fires once every TICK_DIV clkin cycles while running.
//
// state | meaning
// IDLE  | holding value, waiting for run
// RUN   | decrementing on each effective tick
// DONE  | reached 00 with WRAP=0; only a valid load or rst leaves
module bcd_down_counter60 #(
    parameter int MODULUS  = 60,
    parameter bit WRAP     = 1'b1,
    parameter int TICK_DIV = 50000000
) (
    input  logic                     clkin,
    input  logic                     rst,
    bcd_down_counter60_if.slave      bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [3:0] MAX_LO = 4'((MODULUS - 1) % 10);
    localparam logic [3:0] MAX_HI = 4'((MODULUS - 1) / 10);
    localparam logic [7:0] MOD_V  = 8'(MODULUS);

    state_t     state, state_nx;
    logic [3:0] low, low_nx;
    logic [3:0] high, high_nx;
    logic       bo, bo_nx;
    logic       load_err, err_nx;
    logic       load_ok;
    logic       tick_eff;
    logic [7:0] load_val;

    assign load_val = ({4'd0, bus.load_high} * 8'd10) + {4'd0, bus.load_low};
    assign load_ok  = (bus.load_low <= 4'd9) && (bus.load_high <= 4'd9) && (load_val < MOD_V);

`ifdef TICK_DIV_EN
    logic [31:0] presc;

    assign tick_eff = (state == RUN) && (presc == 32'(TICK_DIV - 1));

    // Prescaler runs only in RUN and restarts on any exit from RUN or a valid load.
    always_ff @(posedge clkin) begin
        if (rst) begin
            presc <= '0;
        end else if (state != RUN || (bus.load && load_ok)) begin
            presc <= '0;
        end else if (presc == 32'(TICK_DIV - 1)) begin
            presc <= '0;
        end else begin
            presc <= presc + 32'd1;
        end
    end
`else
    assign tick_eff = bus.tick;
`endif

    // State, digits and pulse outputs registered together.
    always_ff @(posedge clkin) begin
        if (rst) begin
            state    <= IDLE;
            low      <= 4'd0;
            high     <= 4'd0;
            bo       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_nx;
            low      <= low_nx;
            high     <= high_nx;
            bo       <= bo_nx;
            load_err <= err_nx;
        end
    end

    // Next state and digits: load takes priority over counting.
    always_comb begin
        state_nx = state;
        low_nx   = low;
        high_nx  = high;
        bo_nx    = 1'b0;
        err_nx   = 1'b0;
        if (bus.load) begin
            if (load_ok) begin
                low_nx  = bus.load_low;
                high_nx = bus.load_high;
                if (state == DONE) state_nx = IDLE;
            end else begin
                err_nx = 1'b1;
            end
        end else begin
            case (state)
                IDLE: if (bus.run) state_nx = RUN;
                RUN: begin
                    if (!bus.run) begin
                        state_nx = IDLE;
                    end else if (tick_eff) begin
                        if (low != 4'd0) begin
                            low_nx = low - 4'd1;
                            // Reaching 00 by decrement ends a one-shot countdown.
                            if (!WRAP && low == 4'd1 && high == 4'd0) begin
                                bo_nx    = 1'b1;
                                state_nx = DONE;
                            end
                        end else if (high != 4'd0) begin
                            low_nx  = 4'd9;
                            high_nx = high - 4'd1;
                        end else if (WRAP) begin
                            low_nx  = MAX_LO;
                            high_nx = MAX_HI;
                            bo_nx   = 1'b1;
                        end else begin
                            state_nx = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.low      = low;
    assign bus.high     = high;
    assign bus.bo       = bo;
    assign bus.load_err = load_err;
    assign bus.done     = (state == DONE);
    assign bus.zero     = (low == 4'd0) && (high == 4'd0);
endmodule

// File: tb/tb_bcd_down_counter60.sv
// Directed bench for bcd_down_counter60: one wrapping and one one-shot instance.
module tb_bcd_down_counter60;
    logic clkin;
    logic rst;
    int   checks;
    int   errors;

    bcd_down_counter60_if w ();
    bcd_down_counter60_if s ();

    bcd_down_counter60 #(.MODULUS(60), .WRAP(1'b1), .TICK_DIV(4)) u_wrap (
        .clkin(clkin), .rst(rst), .bus(w)
    );
    bcd_down_counter60 #(.MODULUS(60), .WRAP(1'b0), .TICK_DIV(4)) u_stop (
        .clkin(clkin), .rst(rst), .bus(s)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if (w.low !== 4'd0 || w.high !== 4'd0 || w.zero !== 1'b1 || w.bo !== 1'b0
            || w.done !== 1'b0 || w.load_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: got %0d%0d zero=%b bo=%b done=%b err=%b, want 00 1 0 0 0",
                     w.high, w.low, w.zero, w.bo, w.done, w.load_err);
        end
        checks++;
        if (s.low !== 4'd0 || s.high !== 4'd0 || s.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_stop: got %0d%0d done=%b, want 00 0", s.high, s.low, s.done);
        end
        rst = 1'b0;
        w.run = 1'b1;
        step();
        step();
        checks++;
        if (w.low !== 4'd0 || w.high !== 4'd0 || w.zero !== 1'b1 || w.bo !== 1'b0) begin
            errors++;
            $display("FAIL run_no_tick: got %0d%0d zero=%b bo=%b, want 00 1 0",
                     w.high, w.low, w.zero, w.bo);
        end
    endtask

    task automatic test_count_wrap();
        int exp_v;
        logic exp_bo;
        w.load = 1'b1; w.load_low = 4'd2; w.load_high = 4'd3;
        step();
        w.load = 1'b0;
        checks++;
        if (w.high !== 4'd3 || w.low !== 4'd2) begin
            errors++;
            $display("FAIL load32: got %0d%0d, want 32", w.high, w.low);
        end
        w.tick = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            step();
            exp_v  = (i == 33) ? 59 : 32 - i;
            exp_bo = (i == 33);
            checks++;
            if (w.high !== 4'(exp_v / 10) || w.low !== 4'(exp_v % 10) || w.bo !== exp_bo
                || w.zero !== (exp_v == 0)) begin
                errors++;
                $display("FAIL count_%0d: got %0d%0d bo=%b zero=%b, want %0d bo=%b zero=%b",
                         i, w.high, w.low, w.bo, w.zero, exp_v, exp_bo, exp_v == 0);
            end
        end
        w.tick = 1'b0;
        step();
        checks++;
        if (w.bo !== 1'b0 || w.high !== 4'd5 || w.low !== 4'd9) begin
            errors++;
            $display("FAIL bo_single: got %0d%0d bo=%b, want 59 bo=0", w.high, w.low, w.bo);
        end
    endtask

    task automatic test_stop();
        int exp_v;
        s.load = 1'b1; s.load_low = 4'd0; s.load_high = 4'd1;
        step();
        s.load = 1'b0;
        s.run = 1'b1;
        step();
        checks++;
        if (s.high !== 4'd1 || s.low !== 4'd0 || s.done !== 1'b0) begin
            errors++;
            $display("FAIL stop_load: got %0d%0d done=%b, want 10 done=0", s.high, s.low, s.done);
        end
        s.tick = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            exp_v = (i >= 10) ? 0 : 10 - i;
            checks++;
            if (s.high !== 4'(exp_v / 10) || s.low !== 4'(exp_v % 10) || s.bo !== (i == 10)
                || s.done !== (i >= 10)) begin
                errors++;
                $display("FAIL stop_%0d: got %0d%0d bo=%b done=%b, want %0d bo=%b done=%b",
                         i, s.high, s.low, s.bo, s.done, exp_v, i == 10, i >= 10);
            end
        end
        s.tick = 1'b0;
        s.load = 1'b1; s.load_low = 4'd5; s.load_high = 4'd0;
        step();
        s.load = 1'b0;
        checks++;
        if (s.high !== 4'd0 || s.low !== 4'd5 || s.done !== 1'b0 || s.zero !== 1'b0) begin
            errors++;
            $display("FAIL stop_reload: got %0d%0d done=%b zero=%b, want 05 done=0 zero=0",
                     s.high, s.low, s.done, s.zero);
        end
    endtask

    task automatic test_load_err();
        logic [3:0] bad_lo [3] = '{4'd10, 4'd0, 4'd0};
        logic [3:0] bad_hi [3] = '{4'd0, 4'd6, 4'd10};
        w.tick = 1'b1;
        step();
        w.tick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w.load = 1'b1; w.load_low = bad_lo[i]; w.load_high = bad_hi[i];
            step();
            w.load = 1'b0;
            checks++;
            if (w.load_err !== 1'b1 || w.high !== 4'd5 || w.low !== 4'd8) begin
                errors++;
                $display("FAIL bad_load_%0d: got %0d%0d err=%b, want 58 err=1",
                         i, w.high, w.low, w.load_err);
            end
            step();
            checks++;
            if (w.load_err !== 1'b0) begin
                errors++;
                $display("FAIL err_pulse_%0d: got err=%b, want 0", i, w.load_err);
            end
        end
        w.load = 1'b1; w.load_low = 4'd9; w.load_high = 4'd5;
        step();
        w.load = 1'b0;
        checks++;
        if (w.load_err !== 1'b0 || w.high !== 4'd5 || w.low !== 4'd9) begin
            errors++;
            $display("FAIL load59: got %0d%0d err=%b, want 59 err=0", w.high, w.low, w.load_err);
        end
    endtask

    task automatic test_priority();
        w.load = 1'b1; w.load_low = 4'd0; w.load_high = 4'd2;
        step();
        w.load = 1'b1; w.load_low = 4'd7; w.load_high = 4'd4; w.tick = 1'b1;
        step();
        w.load = 1'b0;
        checks++;
        if (w.high !== 4'd4 || w.low !== 4'd7 || w.bo !== 1'b0) begin
            errors++;
            $display("FAIL load_vs_tick: got %0d%0d bo=%b, want 47 bo=0", w.high, w.low, w.bo);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (w.high !== 4'd0 || w.low !== 4'd0 || w.bo !== 1'b0 || w.done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got %0d%0d bo=%b done=%b, want 00 0 0",
                     w.high, w.low, w.bo, w.done);
        end
        w.run = 1'b0;
        step();
        step();
        checks++;
        if (w.high !== 4'd0 || w.low !== 4'd0 || w.bo !== 1'b0) begin
            errors++;
            $display("FAIL idle_tick: got %0d%0d bo=%b, want 00 bo=0", w.high, w.low, w.bo);
        end
        w.tick = 1'b0;
    endtask

`ifdef TICK_DIV_EN
    task automatic test_prescaler();
        int exp_v;
        w.run = 1'b0;
        w.load = 1'b1; w.load_low = 4'd2; w.load_high = 4'd0;
        step();
        w.load = 1'b0;
        w.run = 1'b1;
        step();
        for (int c = 1; c <= 12; c++) begin
            w.tick = ~w.tick;
            step();
            exp_v = (c >= 12) ? 59 : (c >= 8) ? 0 : (c >= 4) ? 1 : 2;
            checks++;
            if (w.high !== 4'(exp_v / 10) || w.low !== 4'(exp_v % 10) || w.bo !== (c == 12)) begin
                errors++;
                $display("FAIL presc_%0d: got %0d%0d bo=%b, want %0d bo=%b",
                         c, w.high, w.low, w.bo, exp_v, c == 12);
            end
        end
        w.run = 1'b0;
        step();
        step();
        w.run = 1'b1;
        step();
        for (int c = 1; c <= 4; c++) begin
            step();
            exp_v = (c == 4) ? 58 : 59;
            checks++;
            if (w.high !== 4'(exp_v / 10) || w.low !== 4'(exp_v % 10)) begin
                errors++;
                $display("FAIL presc_restart_%0d: got %0d%0d, want %0d", c, w.high, w.low, exp_v);
            end
        end
        w.tick = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        w.run = 1'b0; w.tick = 1'b0; w.load = 1'b0; w.load_low = 4'd0; w.load_high = 4'd0;
        s.run = 1'b0; s.tick = 1'b0; s.load = 1'b0; s.load_low = 4'd0; s.load_high = 4'd0;
        test_reset();
        test_count_wrap();
        test_stop();
        test_load_err();
        test_priority();
`ifdef TICK_DIV_EN
        test_prescaler();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
